pipe_hazard_ctrl: RTL and testbench

//  Hazard and forwarding controller for the 5-stage pipelined MIPS CPU (IF/ID/EX/MEM/WB).
//  - Detects load-use hazards and stalls IF/ID for LOAD_LAT cycles.
//  - Flushes wrong-path stages on a taken branch resolved in stage BR_STAGE.
//  - Drives EX operand forwarding selects.
//  - Sits beside the pipe registers; gates their write/flush inputs and PC write.

---
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage MIPS pipe: load-use stall, branch flush, EX operand forwarding.
// Latency: all control outputs are combinational from the current state and inputs, with zero cycles of delay.
// Backpressure: a load-use hit holds PC and IF/ID for LOAD_LAT cycles and bubbles ID/EX; a taken branch overrides the stall.
//
// Ports:
//   clk_i, rst_i                    clock (rising edge), asynchronous active-high reset
//   id_rs/rt_addr_i                 source registers of the instruction in ID
//   ex_rs/rt_addr_i                 source registers of the instruction in EX
//   ex_mem_read_i, ex_dest_addr_i   EX instruction is a load, and its destination register
//   mem_/wb_reg_write_i, _dest_addr_i   register writers in MEM and WB
//   branch_taken_i                  taken branch resolved in stage BR_STAGE
//   pc_write_o, if_id_write_o       load enables for PC and IF/ID
//   id_ex_bubble_o                  insert a NOP into ID/EX
//   if_id/id_ex/ex_mem_flush_o      clear the wrong-path pipe registers
//   fwd_a_o, fwd_b_o                ALU source selects (00 ID/EX, 01 EX/MEM, 10 WB)
//   stall_cnt_o, flush_cnt_o        performance counters
// Optional feature: define HAZ_PERF_CNT_EN to build saturating counters.
// Without it, the counters read 0.

module pipe_hazard_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,   // 1..3
  parameter int BR_STAGE = 2,   // 1=ID, 2=EX, 3=MEM
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] id_rs_addr_i,
  input  logic [ADDR_W-1:0] id_rt_addr_i,
  input  logic [ADDR_W-1:0] ex_rs_addr_i,
  input  logic [ADDR_W-1:0] ex_rt_addr_i,
  input  logic              ex_mem_read_i,
  input  logic [ADDR_W-1:0] ex_dest_addr_i,
  input  logic              mem_reg_write_i,
  input  logic [ADDR_W-1:0] mem_dest_addr_i,
  input  logic              wb_reg_write_i,
  input  logic [ADDR_W-1:0] wb_dest_addr_i,
  input  logic              branch_taken_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              id_ex_bubble_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              ex_mem_flush_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic {RUN, STALL} state_t;

  // The hit cycle is the first stall cycle, so STALL covers the remaining LOAD_LAT-1 cycles.
  localparam logic [1:0] LAT_M1       = 2'(LOAD_LAT - 1);
  localparam logic       FLUSH_ID_EX  = (BR_STAGE >= 2);
  localparam logic       FLUSH_EX_MEM = (BR_STAGE == 3);

  state_t     state, state_nxt;
  logic [1:0] stall_left, stall_left_nxt;
  logic       load_use_hit;

  assign load_use_hit = ex_mem_read_i && (ex_dest_addr_i != '0) &&
                        ((ex_dest_addr_i == id_rs_addr_i) || (ex_dest_addr_i == id_rt_addr_i));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= RUN;
      stall_left <= 2'd0;
    end else begin
      state      <= state_nxt;
      stall_left <= stall_left_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    stall_left_nxt = stall_left;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_bubble_o = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    ex_mem_flush_o = 1'b0;
    fwd_a_o        = 2'b00;
    fwd_b_o        = 2'b00;

    // While reset is high, every output stays at its default, whatever the inputs are.
    if (!rst_i) begin
      // The MEM result is newer than the WB result, so MEM is tested first. Register 0 is never forwarded.
      if (mem_reg_write_i && mem_dest_addr_i != '0 && mem_dest_addr_i == ex_rs_addr_i)
        fwd_a_o = 2'b01;
      else if (wb_reg_write_i && wb_dest_addr_i != '0 && wb_dest_addr_i == ex_rs_addr_i)
        fwd_a_o = 2'b10;

      if (mem_reg_write_i && mem_dest_addr_i != '0 && mem_dest_addr_i == ex_rt_addr_i)
        fwd_b_o = 2'b01;
      else if (wb_reg_write_i && wb_dest_addr_i != '0 && wb_dest_addr_i == ex_rt_addr_i)
        fwd_b_o = 2'b10;

      if (branch_taken_i) begin
        // The stalled instruction is on the wrong path, so any pending stall is dropped.
        if_id_flush_o  = 1'b1;
        id_ex_flush_o  = FLUSH_ID_EX;
        ex_mem_flush_o = FLUSH_EX_MEM;
        state_nxt      = RUN;
        stall_left_nxt = 2'd0;
      end else if (state == STALL) begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        id_ex_bubble_o = 1'b1;
        stall_left_nxt = stall_left - 2'd1;
        if (stall_left <= 2'd1) begin
          state_nxt      = RUN;
          stall_left_nxt = 2'd0;
        end
      end else if (load_use_hit) begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        id_ex_bubble_o = 1'b1;
        if (LOAD_LAT > 1) begin
          state_nxt      = STALL;
          stall_left_nxt = LAT_M1;
        end
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_o && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (branch_taken_i && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl using two instances that share one set of inputs.
// Instance A: LOAD_LAT=3, BR_STAGE=3, CNT_W=4. Instance B: LOAD_LAT=1, BR_STAGE=2, CNT_W=16.
// Inputs are driven on the falling edge and outputs are sampled 2 ns later.

module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic       ex_rd, mem_w, wb_w, br;

  logic       a_pc, a_ifid, a_bub, a_f1, a_f2, a_f3;
  logic [1:0] a_fa, a_fb;
  logic [3:0] a_sc, a_fc;
  logic       b_pc, b_ifid, b_bub, b_f1, b_f2, b_f3;
  logic [1:0] b_fa, b_fb;
  logic [15:0] b_sc, b_fc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .BR_STAGE(3), .CNT_W(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst_i),
    .id_rs_addr_i(id_rs), .id_rt_addr_i(id_rt), .ex_rs_addr_i(ex_rs), .ex_rt_addr_i(ex_rt),
    .ex_mem_read_i(ex_rd), .ex_dest_addr_i(ex_dest),
    .mem_reg_write_i(mem_w), .mem_dest_addr_i(mem_dest),
    .wb_reg_write_i(wb_w), .wb_dest_addr_i(wb_dest), .branch_taken_i(br),
    .pc_write_o(a_pc), .if_id_write_o(a_ifid), .id_ex_bubble_o(a_bub),
    .if_id_flush_o(a_f1), .id_ex_flush_o(a_f2), .ex_mem_flush_o(a_f3),
    .fwd_a_o(a_fa), .fwd_b_o(a_fb), .stall_cnt_o(a_sc), .flush_cnt_o(a_fc));

  pipe_hazard_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .BR_STAGE(2), .CNT_W(16)) u_dut_b (
    .clk_i(clk), .rst_i(rst_i),
    .id_rs_addr_i(id_rs), .id_rt_addr_i(id_rt), .ex_rs_addr_i(ex_rs), .ex_rt_addr_i(ex_rt),
    .ex_mem_read_i(ex_rd), .ex_dest_addr_i(ex_dest),
    .mem_reg_write_i(mem_w), .mem_dest_addr_i(mem_dest),
    .wb_reg_write_i(wb_w), .wb_dest_addr_i(wb_dest), .branch_taken_i(br),
    .pc_write_o(b_pc), .if_id_write_o(b_ifid), .id_ex_bubble_o(b_bub),
    .if_id_flush_o(b_f1), .id_ex_flush_o(b_f2), .ex_mem_flush_o(b_f3),
    .fwd_a_o(b_fa), .fwd_b_o(b_fb), .stall_cnt_o(b_sc), .flush_cnt_o(b_fc));

  // Observed control word: {pc, if_id_write, bubble, if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b}
  logic [9:0] a_obs, b_obs;
  assign a_obs = {a_pc, a_ifid, a_bub, a_f1, a_f2, a_f3, a_fa, a_fb};
  assign b_obs = {b_pc, b_ifid, b_bub, b_f1, b_f2, b_f3, b_fa, b_fb};

  typedef struct {
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
    logic       ex_rd;
    logic [4:0] ex_dest;
    logic       mem_w;
    logic [4:0] mem_d;
    logic       wb_w;
    logic [4:0] wb_d;
    logic       br;
    logic       exp_stall;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [4:0] irs, input logic [4:0] irt,
                              input logic [4:0] ers, input logic [4:0] ert,
                              input logic erd, input logic [4:0] ed,
                              input logic mw, input logic [4:0] md,
                              input logic ww, input logic [4:0] wd,
                              input logic b, input logic st,
                              input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.id_rs = irs; v.id_rt = irt; v.ex_rs = ers; v.ex_rt = ert;
    v.ex_rd = erd; v.ex_dest = ed; v.mem_w = mw; v.mem_d = md;
    v.wb_w = ww; v.wb_d = wd; v.br = b; v.exp_stall = st;
    v.exp_fa = fa; v.exp_fb = fb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_dest = 0;
    mem_w = 0; mem_dest = 0; wb_w = 0; wb_dest = 0; br = 0;
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.id_rs; id_rt = v.id_rt; ex_rs = v.ex_rs; ex_rt = v.ex_rt;
    ex_rd = v.ex_rd; ex_dest = v.ex_dest; mem_w = v.mem_w; mem_dest = v.mem_d;
    wb_w = v.wb_w; wb_dest = v.wb_d; br = v.br;
  endtask

  task automatic hit8();
    idle(); ex_rd = 1; ex_dest = 5'd8; id_rs = 5'd8;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_i = 1'b1; idle();
    @(negedge clk); rst_i = 1'b0;
  endtask

  // Expected counter value, or 0 when the counters are compiled out.
  function automatic logic [31:0] cnt(input int n);
`ifdef HAZ_PERF_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  initial begin
    //        irs irt ers ert rd dst mw md ww wd br stall fa     fb
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[1]  = mk(8, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00);
    vecs[2]  = mk(1, 8, 0, 0, 1, 8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00);
    vecs[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[4]  = mk(8, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    vecs[5]  = mk(8, 0, 0, 0, 1, 8, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00);
    vecs[6]  = mk(0, 0, 5, 5, 0, 0, 1, 5, 1, 5, 0, 0, 2'b01, 2'b01);
    vecs[7]  = mk(0, 0, 5, 0, 0, 0, 1, 0, 1, 5, 0, 0, 2'b10, 2'b00);
    vecs[8]  = mk(0, 0, 5, 5, 0, 0, 0, 5, 1, 5, 0, 0, 2'b10, 2'b10);
    vecs[9]  = mk(0, 0, 4, 3, 0, 0, 1, 3, 1, 4, 0, 0, 2'b10, 2'b01);
    vecs[10] = mk(0, 0, 2, 7, 0, 0, 1, 7, 0, 7, 0, 0, 2'b00, 2'b01);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00);
    vecs[12] = mk(3, 3, 6, 6, 1, 3, 1, 6, 0, 0, 1, 0, 2'b01, 2'b01);

    // Reset: outputs must be forced even while a load-use hit and forwarding are presented.
    rst_i = 1'b1;
    hit8(); mem_w = 1; mem_dest = 5'd5; ex_rs = 5'd5; ex_rt = 5'd5;
    #2;
    chk("reset_obs_a", a_obs, 10'b11_0000_0000);
    chk("reset_obs_b", b_obs, 10'b11_0000_0000);
    chk("reset_cnt_a", {a_sc, a_fc}, 0);
    chk("reset_cnt_b", {b_sc, b_fc}, 0);
    idle();
    @(negedge clk); rst_i = 1'b0;

    // Single-cycle vectors. Inputs return to idle before the next rising edge, so the state stays RUN.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk($sformatf("vec%0d_a", i), a_obs,
          {~vecs[i].exp_stall, ~vecs[i].exp_stall, vecs[i].exp_stall,
           vecs[i].br, vecs[i].br, vecs[i].br, vecs[i].exp_fa, vecs[i].exp_fb});
      chk($sformatf("vec%0d_b", i), b_obs,
          {~vecs[i].exp_stall, ~vecs[i].exp_stall, vecs[i].exp_stall,
           vecs[i].br, vecs[i].br, 1'b0, vecs[i].exp_fa, vecs[i].exp_fb});
      #1 idle();
    end

    // lw $8 in EX, ID reads $8. B stalls for 1 cycle, A stalls for 3.
    @(negedge clk); hit8(); #2;
    chk("ldu_c0_pc_a", a_pc, 0);
    chk("ldu_c0_pc_b", b_pc, 0);
    chk("ldu_c0_bub_b", b_bub, 1);
    @(negedge clk); idle(); ex_rs = 5'd8; wb_w = 1; wb_dest = 5'd8; #2;
    chk("ldu_c1_pc_b", b_pc, 1);
    chk("ldu_c1_fwd_b", b_fa, 2'b10);
    chk("ldu_c1_pc_a", a_pc, 0);
    @(negedge clk); idle(); #2;
    chk("ldu_c2_a", {a_pc, a_ifid, a_bub}, 3'b001);
    @(negedge clk); #2;
    chk("ldu_c3_pc_a", a_pc, 1);
    chk("ldu_scnt_a", a_sc, cnt(3));
    chk("ldu_scnt_b", b_sc, cnt(1));
    chk("ldu_fcnt_a", a_fc, cnt(0));

    // A taken branch during A's stall with 2 cycles left.
    pulse_reset();
    @(negedge clk); hit8(); #2;
    chk("brs_c0_pc_a", a_pc, 0);
    @(negedge clk); idle(); br = 1; #2;
    chk("brs_c1_a", {a_pc, a_bub, a_f1, a_f2, a_f3}, 5'b10111);
    chk("brs_c1_b", {b_pc, b_f1, b_f2, b_f3}, 4'b1110);
    @(negedge clk); br = 0; #2;
    chk("brs_c2_a", {a_pc, a_ifid, a_bub}, 3'b110);
    chk("brs_scnt_a", a_sc, cnt(1));
    chk("brs_fcnt_a", a_fc, cnt(1));
    chk("brs_fcnt_b", b_fc, cnt(1));

    // Reset asserted mid-stall takes effect without waiting for a clock edge.
    @(negedge clk); hit8();
    @(negedge clk); idle(); mem_w = 1; mem_dest = 5'd5; ex_rs = 5'd5; #2;
    chk("rst_pre_pc_a", a_pc, 0);
    rst_i = 1'b1; #1;
    chk("rst_mid_obs_a", a_obs, 10'b11_0000_0000);
    chk("rst_mid_cnt_a", {a_sc, a_fc}, 0);
    @(negedge clk); rst_i = 1'b0; idle(); #2;
    chk("rst_post0_pc_a", a_pc, 1);
    @(negedge clk); #2;
    chk("rst_post1_pc_a", a_pc, 1);

    // 20 consecutive stalled cycles. The 4-bit counter in A saturates at 15.
    @(negedge clk); hit8();
    repeat (20) @(negedge clk);
    idle(); #2;
    chk("sat_scnt_a", a_sc, cnt(15));
    chk("sat_scnt_b", b_sc, cnt(20));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
